// File: rtl/dsp_simd_pkg.sv
// Shared types and helpers for the SIMD ALU: opcode encoding, the widest
// supported datapath and the signed saturation clamp.
package dsp_simd_pkg;

   localparam int MAX_BITS = 48;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NAND = 4'd5,
      OP_NOR  = 4'd6,
      OP_XNOR = 4'd7,
      OP_NOT  = 4'd8,
      OP_ACC  = 4'd9,
      OP_LDA  = 4'd10
   } op_t;

   // sum is the (width+1)-bit sign-extended result, zero-padded above that;
   // bit [width] is the true sign, so it picks the clamp direction.
   function automatic logic [MAX_BITS-1:0] sat_clamp(
      input int                  width,
      input logic [MAX_BITS:0]   sum,
      input logic                ovf
   );
      logic [MAX_BITS-1:0] res;
      logic                neg;
      neg = |(sum & ((MAX_BITS+1)'(1) << width));
      res = sum[MAX_BITS-1:0];
      if (ovf) begin
         for (int i = 0; i < MAX_BITS; i++) begin
            if (i < width) begin
               res[i] = (i == width - 1) ? neg : !neg;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/dsp_simd_lane.sv
// One combinational ALU lane: opcode decode, signed overflow detection and
// optional saturation. The accumulator value is supplied by the owner.
module dsp_simd_lane
   import dsp_simd_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic [3:0]       op_i,
   input  logic             sat_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [WIDTH-1:0] acc_i,
   output logic [WIDTH-1:0] y_o,
   output logic             ovf_o
);

   logic [WIDTH:0]   opx;
   logic [WIDTH:0]   opy;
   logic [WIDTH:0]   sum;
   logic             raw_ovf;
   logic [WIDTH-1:0] arith_y;

   // ACC reuses the adder with the accumulator as the first operand.
   always_comb begin
      opx = {a_i[WIDTH-1], a_i};
      opy = {b_i[WIDTH-1], b_i};
      if (op_i == OP_ACC) begin
         opx = {acc_i[WIDTH-1], acc_i};
         opy = {a_i[WIDTH-1], a_i};
      end
      sum = (op_i == OP_SUB) ? (opx - opy) : (opx + opy);
   end

   assign raw_ovf = sum[WIDTH] ^ sum[WIDTH-1];
   assign arith_y = sat_i ? WIDTH'(sat_clamp(WIDTH, (MAX_BITS+1)'(sum), raw_ovf))
                          : sum[WIDTH-1:0];

   always_comb begin
      y_o   = '0;
      ovf_o = 1'b0;
      case (op_i)
         OP_ADD, OP_SUB, OP_ACC: begin
            y_o   = arith_y;
            ovf_o = raw_ovf;
         end
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_NAND: y_o = ~(a_i & b_i);
         OP_NOR:  y_o = ~(a_i | b_i);
         OP_XNOR: y_o = ~(a_i ^ b_i);
         OP_NOT:  y_o = ~a_i;
         OP_LDA:  y_o = a_i;
         default: begin
            y_o   = '0;
            ovf_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dsp_simd_alu.sv
// Two-stage SIMD ALU: S1 registers the operand beat, S2 registers the lane
// results. One global advance enable gives valid/ready backpressure.
module dsp_simd_alu
   import dsp_simd_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int WIDTH  = 12,
   parameter int SAT_EN = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [3:0]             op_i,
   input  logic                   sat_mode_i,
   input  logic [LANES*WIDTH-1:0] a_i,
   input  logic [LANES*WIDTH-1:0] b_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [LANES*WIDTH-1:0] y_o,
   output logic [LANES-1:0]       ovf_o
);

   localparam int DW = LANES * WIDTH;

   if (LANES < 1 || LANES > 4 || LANES * WIDTH > MAX_BITS) begin : g_bad_params
      $error("dsp_simd_alu: LANES must be 1..4 and LANES*WIDTH <= 48");
   end

   logic          adv;
   logic          sat_eff;

   logic          s1_valid_q, s1_valid_d;
   logic [3:0]    s1_op_q,    s1_op_d;
   logic          s1_sat_q,   s1_sat_d;
   logic [DW-1:0] s1_a_q,     s1_a_d;
   logic [DW-1:0] s1_b_q,     s1_b_d;

   logic             s2_valid_q, s2_valid_d;
   logic [DW-1:0]    y_q,        y_d;
   logic [LANES-1:0] ovf_q,      ovf_d;
   logic [DW-1:0]    acc_q,      acc_d;

   logic [DW-1:0]    lane_y;
   logic [LANES-1:0] lane_ovf;

   assign adv     = !s2_valid_q || out_ready_i;
   assign sat_eff = (SAT_EN != 0) && sat_mode_i;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      dsp_simd_lane #(
         .WIDTH (WIDTH)
      ) u_lane (
         .op_i  (s1_op_q),
         .sat_i (s1_sat_q),
         .a_i   (s1_a_q[gi*WIDTH +: WIDTH]),
         .b_i   (s1_b_q[gi*WIDTH +: WIDTH]),
         .acc_i (acc_q[gi*WIDTH +: WIDTH]),
         .y_o   (lane_y[gi*WIDTH +: WIDTH]),
         .ovf_o (lane_ovf[gi])
      );
   end

   // The accumulator commits as the beat enters S2, so a following ACC in S1
   // already sees the updated value and chains without a bubble.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_sat_d   = s1_sat_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      y_d        = y_q;
      ovf_d      = ovf_q;
      acc_d      = acc_q;
      if (adv) begin
         s1_valid_d = in_valid_i;
         if (in_valid_i) begin
            s1_op_d  = op_i;
            s1_sat_d = sat_eff;
            s1_a_d   = a_i;
            s1_b_d   = b_i;
         end
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            y_d   = lane_y;
            ovf_d = lane_ovf;
            if (s1_op_q == OP_ACC || s1_op_q == OP_LDA) begin
               acc_d = lane_y;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_sat_q   <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         y_q        <= '0;
         ovf_q      <= '0;
         acc_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_sat_q   <= s1_sat_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         y_q        <= y_d;
         ovf_q      <= ovf_d;
         acc_q      <= acc_d;
      end
   end

   assign in_ready_o  = adv;
   assign out_valid_o = s2_valid_q;
   assign y_o         = y_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_dsp_simd_alu.sv
// Directed bench for dsp_simd_alu across three lane/width configurations.
module tb_dsp_simd_alu;
   import dsp_simd_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input bit ok,
                      input logic [79:0] obs, input logic [79:0] exp);
      n_assert++;
      if (!ok) begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("PASS %s: 0x%0h", tag, obs);
      end
   endtask

   // 4 lanes x 12 bits, no saturation hardware
   logic        a4_in_valid, a4_in_ready, a4_sat, a4_out_valid, a4_out_ready;
   logic [3:0]  a4_op;
   logic [47:0] a4_a, a4_b, a4_y;
   logic [3:0]  a4_ovf;

   // 2 lanes x 24 bits, saturation enabled
   logic        b2_in_valid, b2_in_ready, b2_sat, b2_out_valid, b2_out_ready;
   logic [3:0]  b2_op;
   logic [47:0] b2_a, b2_b, b2_y;
   logic [1:0]  b2_ovf;

   // 1 lane x 32 bits, saturation enabled
   logic        c1_in_valid, c1_in_ready, c1_sat, c1_out_valid, c1_out_ready;
   logic [3:0]  c1_op;
   logic [31:0] c1_a, c1_b, c1_y;
   logic [0:0]  c1_ovf;

   dsp_simd_alu #(.LANES(4), .WIDTH(12), .SAT_EN(0)) u_a4 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(a4_in_valid), .in_ready_o(a4_in_ready),
      .op_i(a4_op), .sat_mode_i(a4_sat), .a_i(a4_a), .b_i(a4_b),
      .out_valid_o(a4_out_valid), .out_ready_i(a4_out_ready), .y_o(a4_y), .ovf_o(a4_ovf));

   dsp_simd_alu #(.LANES(2), .WIDTH(24), .SAT_EN(1)) u_b2 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(b2_in_valid), .in_ready_o(b2_in_ready),
      .op_i(b2_op), .sat_mode_i(b2_sat), .a_i(b2_a), .b_i(b2_b),
      .out_valid_o(b2_out_valid), .out_ready_i(b2_out_ready), .y_o(b2_y), .ovf_o(b2_ovf));

   dsp_simd_alu #(.LANES(1), .WIDTH(32), .SAT_EN(1)) u_c1 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(c1_in_valid), .in_ready_o(c1_in_ready),
      .op_i(c1_op), .sat_mode_i(c1_sat), .a_i(c1_a), .b_i(c1_b),
      .out_valid_o(c1_out_valid), .out_ready_i(c1_out_ready), .y_o(c1_y), .ovf_o(c1_ovf));

   logic [3:0]  sw_op  [0:7];
   logic [31:0] sw_a   [0:7];
   logic [31:0] sw_exp [0:7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          sent;
      int          got;
      int          stalls;
      logic        stalled_prev;
      logic [31:0] held;

      a4_in_valid = 1'b0; a4_op = '0; a4_sat = 1'b0; a4_a = '0; a4_b = '0; a4_out_ready = 1'b1;
      b2_in_valid = 1'b0; b2_op = '0; b2_sat = 1'b0; b2_a = '0; b2_b = '0; b2_out_ready = 1'b1;
      c1_in_valid = 1'b0; c1_op = '0; c1_sat = 1'b0; c1_a = '0; c1_b = '0; c1_out_ready = 1'b1;

      sw_op  = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_XNOR, OP_NAND, OP_NOT, 4'hF};
      sw_a   = '{32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd14893, 32'd10};
      sw_exp = '{32'h0, 32'hB, 32'hB, 32'hFFFFFFF4, 32'hFFFFFFF4, 32'hFFFFFFFF,
                 32'hFFFFC5D2, 32'h0};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {a4_out_valid, b2_out_valid, c1_out_valid} === 3'b000,
          {a4_out_valid, b2_out_valid, c1_out_valid}, 3'b000);
      chk("rst_in_ready", {a4_in_ready, b2_in_ready, c1_in_ready} === 3'b111,
          {a4_in_ready, b2_in_ready, c1_in_ready}, 3'b111);
      chk("rst_y", {a4_y, c1_y} === 80'h0, {a4_y, c1_y}, 80'h0);
      chk("rst_ovf", {a4_ovf, b2_ovf, c1_ovf} === 7'b0, {a4_ovf, b2_ovf, c1_ovf}, 7'b0);
      @(posedge clk); #1 rst_n = 1'b1;

      // 4x12 ADD wrap: plain vector, then overflow vector with sat_mode ignored
      @(posedge clk); #1;
      a4_in_valid = 1'b1; a4_op = OP_ADD; a4_sat = 1'b0;
      a4_a = {12'hFEC, 12'h0FF, 12'h017, 12'hFFF};
      a4_b = {12'hFF9, 12'h007, 12'h007, 12'h010};
      @(posedge clk); #1;
      a4_sat = 1'b1;
      a4_a = {12'h000, 12'h100, 12'h800, 12'h7FF};
      a4_b = {12'h000, 12'h200, 12'hFFF, 12'h001};
      @(negedge clk);
      chk("add4_latency1_valid", a4_out_valid === 1'b0, a4_out_valid, 1'b0);
      @(posedge clk); #1 a4_in_valid = 1'b0;
      @(negedge clk);
      chk("add4_v1_valid", a4_out_valid === 1'b1, a4_out_valid, 1'b1);
      chk("add4_v1_y", a4_y === {12'hFE5, 12'h106, 12'h01E, 12'h00F},
          a4_y, {12'hFE5, 12'h106, 12'h01E, 12'h00F});
      chk("add4_v1_ovf", a4_ovf === 4'b0000, a4_ovf, 4'b0000);
      @(posedge clk);
      @(negedge clk);
      chk("add4_v2_y", a4_y === {12'h000, 12'h300, 12'h7FF, 12'h800},
          a4_y, {12'h000, 12'h300, 12'h7FF, 12'h800});
      chk("add4_v2_ovf", a4_ovf === 4'b0011, a4_ovf, 4'b0011);
      @(posedge clk);
      @(negedge clk);
      chk("add4_drain_valid", a4_out_valid === 1'b0, a4_out_valid, 1'b0);

      // 2x24 saturate: SUB, ADD sat, ADD wrap back-to-back
      @(posedge clk); #1;
      b2_in_valid = 1'b1; b2_op = OP_SUB; b2_sat = 1'b1;
      b2_a = {24'd23, 24'h7FFFFF};
      b2_b = {24'd7,  24'hFFFFFF};
      @(posedge clk); #1;
      b2_op = OP_ADD;
      b2_a = {24'h800000, 24'h7FFFF0};
      b2_b = {24'hFFFFFF, 24'h000020};
      @(posedge clk); #1;
      b2_sat = 1'b0;
      @(negedge clk);
      chk("sub2_sat_y", b2_y === {24'd16, 24'h7FFFFF}, b2_y, {24'd16, 24'h7FFFFF});
      chk("sub2_sat_ovf", b2_ovf === 2'b01, b2_ovf, 2'b01);
      @(posedge clk); #1 b2_in_valid = 1'b0;
      @(negedge clk);
      chk("add2_sat_y", b2_y === {24'h800000, 24'h7FFFFF}, b2_y, {24'h800000, 24'h7FFFFF});
      chk("add2_sat_ovf", b2_ovf === 2'b11, b2_ovf, 2'b11);
      @(posedge clk);
      @(negedge clk);
      chk("add2_wrap_y", b2_y === {24'h7FFFFF, 24'h800010}, b2_y, {24'h7FFFFF, 24'h800010});
      chk("add2_wrap_ovf", b2_ovf === 2'b11, b2_ovf, 2'b11);

      // 1x32 accumulator chain: LDA 5, ACC 3, ACC -2
      @(posedge clk); #1;
      c1_in_valid = 1'b1; c1_op = OP_LDA; c1_sat = 1'b0; c1_a = 32'd5; c1_b = 32'd0;
      @(posedge clk); #1 c1_op = OP_ACC; c1_a = 32'd3;
      @(posedge clk); #1 c1_a = 32'hFFFFFFFE;
      @(negedge clk);
      chk("acc_lda_y", c1_y === 32'd5, c1_y, 32'd5);
      @(posedge clk); #1 c1_in_valid = 1'b0;
      @(negedge clk);
      chk("acc_chain1_valid", c1_out_valid === 1'b1, c1_out_valid, 1'b1);
      chk("acc_chain1_y", c1_y === 32'd8, c1_y, 32'd8);
      @(posedge clk);
      @(negedge clk);
      chk("acc_chain2_y", c1_y === 32'd6, c1_y, 32'd6);
      chk("acc_chain2_ovf", c1_ovf === 1'b0, c1_ovf, 1'b0);

      // Logic sweep plus an undefined opcode, streamed at full rate
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (k < 8) begin
            c1_in_valid = 1'b1; c1_op = sw_op[k]; c1_a = sw_a[k]; c1_b = 32'd1;
         end else begin
            c1_in_valid = 1'b0;
         end
         @(negedge clk);
         if (k >= 2) begin
            chk("logic_y", c1_y === sw_exp[k-2], c1_y, sw_exp[k-2]);
            chk("logic_valid", c1_out_valid === 1'b1, c1_out_valid, 1'b1);
            chk("logic_ovf", c1_ovf === 1'b0, c1_ovf, 1'b0);
         end
      end

      // Backpressure: ADD 1..6 (+1), consumer stalls for cycles 3-5
      sent = 0; got = 0; stalls = 0; stalled_prev = 1'b0; held = '0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         @(posedge clk); #1;
         c1_out_ready = !(cyc >= 3 && cyc <= 5);
         c1_in_valid  = (sent < 6);
         c1_op = OP_ADD; c1_a = 32'(sent + 1); c1_b = 32'd1;
         @(negedge clk);
         if (stalled_prev) chk("bp_y_stable", c1_y === held, c1_y, held);
         if (c1_out_valid && !c1_out_ready) begin
            chk("bp_in_ready_low", c1_in_ready === 1'b0, c1_in_ready, 1'b0);
            held = c1_y;
            stalled_prev = 1'b1;
            stalls++;
         end else begin
            stalled_prev = 1'b0;
         end
         if (c1_out_valid && c1_out_ready) begin
            chk("bp_y", c1_y === 32'(got + 2), c1_y, 32'(got + 2));
            got++;
         end
         if (c1_in_valid && c1_in_ready) sent++;
      end
      chk("bp_outputs", got == 6, got, 6);
      chk("bp_stall_cycles", stalls == 3, stalls, 3);
      @(posedge clk); #1 c1_in_valid = 1'b0; c1_out_ready = 1'b1;

      // Async reset with two beats in flight, then accumulator must be clear
      @(posedge clk); #1;
      c1_in_valid = 1'b1; c1_op = OP_LDA; c1_a = 32'd100;
      @(posedge clk); #1 c1_op = OP_ACC; c1_a = 32'd1;
      @(posedge clk); #1 c1_a = 32'd2;
      @(posedge clk); #1 c1_in_valid = 1'b0;
      chk("rst_mid_pre_valid", c1_out_valid === 1'b1, c1_out_valid, 1'b1);
      chk("rst_mid_pre_y", c1_y === 32'd101, c1_y, 32'd101);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", c1_out_valid === 1'b0, c1_out_valid, 1'b0);
      chk("rst_mid_y", c1_y === 32'd0, c1_y, 32'd0);
      chk("rst_mid_in_ready", c1_in_ready === 1'b1, c1_in_ready, 1'b1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      c1_in_valid = 1'b1; c1_op = OP_ACC; c1_a = 32'd4;
      @(posedge clk); #1 c1_in_valid = 1'b0;
      @(negedge clk);
      chk("rst_dropped_valid", c1_out_valid === 1'b0, c1_out_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_acc_valid", c1_out_valid === 1'b1, c1_out_valid, 1'b1);
      chk("rst_acc_y", c1_y === 32'd4, c1_y, 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dsp_simd_alu.md
Name: dsp_simd_alu

Overview:
- Parametrised, pipelined SIMD ALU that generalises the fixed-lane dsp_add / dsp_sub / dsp_logic primitives (v2/v3/v4 variants) into one block.
- Runtime opcode select, per-lane wrap or signed-saturate arithmetic, a per-lane accumulator, and a valid/ready handshake with backpressure.
- Sits between the Reticle instruction layer and the DSP48-mapped datapath; one instance models one DSP slice's SIMD ALU.

Parameters:
- LANES, 4, number of independent lanes; legal values 1..4.
- WIDTH, 12, bits per lane; LANES*WIDTH <= 48 (elaboration-time assertion).
- SAT_EN, 0, 1 instantiates signed-saturation logic; 0 ties sat_mode off.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; deassertion synchronised externally.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- op  in  4  opcode (package enum).
- sat_mode  in  1  1 = signed saturate on ADD/SUB/ACC; ignored when SAT_EN=0.
- a  in  LANES*WIDTH  lane i = a[i*WIDTH +: WIDTH].
- b  in  LANES*WIDTH  same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- y  out  LANES*WIDTH  result, same packing.
- ovf  out  LANES  per-lane signed overflow flag (raw, pre-saturation).

Behaviour:
- Opcodes: ADD a+b; SUB a-b; AND; OR; XOR; NAND; NOR; XNOR; NOT ~a (b ignored); ACC acc+a; LDA acc=a, y=a. Undefined codes produce y=0, ovf=0, valid still propagates.
- Lanes are fully independent; no carry crosses a lane boundary.
- Wrap mode: result is the low WIDTH bits.
- Saturate mode: on signed overflow, clamp to 0x7FF..F / 0x800..0. ovf is set whenever overflow occurs, regardless of mode. Logic ops always drive ovf=0.
- Pipeline has 2 stages: S1 (A/B/op register) and S2 (P register).
  - Latency is exactly 2 cycles from an accepted beat to out_valid when out_ready is held high.
  - Full throughput: 1 beat/cycle.
- Global advance: adv = !s2_valid || out_ready.
  - in_ready = adv.
  - On adv, S1 loads the input beat (s1_valid <= in_valid) and S2 loads the S1 result.
  - When !adv, all registers hold; y, ovf and out_valid are stable while out_valid && !out_ready.
- Accumulator (LANES x WIDTH):
  - Updated only when an ACC or LDA beat moves from S1 into S2.
  - ACC uses the same wrap/saturate rule as ADD.
  - Back-to-back ACC beats chain correctly: S2 uses the accumulator value that includes the previous beat; no hazard bubble.
- Reset (asynchronous assert, any time, including mid-stall):
  - s1_valid = s2_valid = 0, out_valid = 0, y = 0, ovf = 0, accumulator = 0, in_ready = 1.
  - In-flight beats are dropped.
- Boundaries:
  - in_valid with !in_ready: the beat is not taken; the producer must hold it.
  - A bubble (in_valid=0) on adv clears s1_valid.
  - LANES=1, WIDTH=48 degenerates to a full-width ALU.

Decomposition:
- Package dsp_simd_pkg:
  - op_t enum (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NAND=5, NOR=6, XNOR=7, NOT=8, ACC=9, LDA=10).
  - MAX_BITS=48.
  - Function sat_clamp(width, sum, ovf).
- One sub-module dsp_simd_lane: purely combinational single-lane op/overflow/saturate, generated LANES times. The top level owns the pipeline, handshake and accumulator registers.

Test Plan:
- LANES=4, WIDTH=12, ADD, wrap; lanes (a,b) = (0xFFF,0x010), (23,7), (255,7), (0xFEC,0xFF9) -> 2 cycles later y lanes = 0x00F, 30, 262, 0xFE5; ovf=0000.
- LANES=2, WIDTH=24, SUB, sat_mode=1, SAT_EN=1; lane0 0x7FFFFF - 0xFFFFFF(-1) -> y0=0x7FFFFF, ovf[0]=1; lane1 23-7 -> y1=16, ovf[1]=0.
- LANES=1, WIDTH=32, LDA a=5 then ACC a=3, ACC a=0xFFFFFFFE back-to-back -> y sequence 5, 8, 6 on consecutive cycles.
- Backpressure: stream ADD beats 1..6 (b=1), hold out_ready=0 for cycles 3-5 -> in_ready low while stalled; y held stable; outputs 2..7 in order, none lost or duplicated.
- Async reset pulse mid-stream with 2 beats in flight -> out_valid=0, y=0 immediately; a following ACC a=4 yields y=4 (accumulator cleared).
- Logic sweep, LANES=1, WIDTH=32, a=10, b=1: AND/OR/XOR/NOR/XNOR/NAND -> 0, 11, 11, 0xFFFFFFF4, 0xFFFFFFF4, 0xFFFFFFFF; NOT a=14893 -> 0xFFFFC5D2.
